// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Shares one single-port, word-addressed instruction memory between the core
// fetch stage (read-only) and the program loader / debug port (read/write).
// Both sides use valid/ready request and response handshakes, and only one
// transaction is in flight at a time. The loader normally wins arbitration,
// but after STARVE_MAX loader grants taken while fetch was waiting, fetch is
// forced through.
//
// Parameters
//   DEPTH       number of 32-bit words in the memory
//   STARVE_MAX  loader grants tolerated while fetch waits before fetch wins
//
// Ports
//   clk, rst                       clock; synchronous active-low reset
//   f_req_valid/ready, f_req_addr  fetch read request (byte address)
//   f_rsp_valid/ready              fetch response handshake
//   f_rsp_data, f_rsp_err          instruction word; bad-address flag
//   l_req_valid/ready              loader request handshake
//   l_req_we, l_req_addr           write select; byte address
//   l_req_wdata, l_req_be          write data; byte enables
//   l_rsp_valid/ready              loader response handshake
//   l_rsp_data, l_rsp_err          read data (0 for writes/errors); bad-address flag
//   mem_en, mem_we                 memory strobe; per-byte write strobe (0 = read)
//   mem_addr, mem_wdata            word index; write data
//   mem_rdata                      read data, valid the cycle after a read strobe
// -----------------------------------------------------------------------------
module imem_arbiter #(
  parameter int DEPTH      = 1024,
  parameter int STARVE_MAX = 4,
  localparam int IW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          f_req_valid,
  output logic          f_req_ready,
  input  logic [31:0]   f_req_addr,
  output logic          f_rsp_valid,
  input  logic          f_rsp_ready,
  output logic [31:0]   f_rsp_data,
  output logic          f_rsp_err,

  input  logic          l_req_valid,
  output logic          l_req_ready,
  input  logic          l_req_we,
  input  logic [31:0]   l_req_addr,
  input  logic [31:0]   l_req_wdata,
  input  logic [3:0]    l_req_be,
  output logic          l_rsp_valid,
  input  logic          l_rsp_ready,
  output logic [31:0]   l_rsp_data,
  output logic          l_rsp_err,

  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [IW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  // Starvation counter must be able to hold STARVE_MAX itself.
  localparam int            CW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH  = 1'b0,
    OWN_LOADER = 1'b1
  } owner_t;

  state_t        state,      state_d;
  owner_t        owner,      owner_d;
  logic [31:0]   rsp_data,   rsp_data_d;
  logic          rsp_err,    rsp_err_d;
  logic [CW-1:0] starve_cnt, starve_cnt_d;

  // ---------------------------------------------------------------------------
  // Arbitration and address decode for the request that would be accepted in
  // IDLE. These are pure functions of the inputs and the starvation counter;
  // the FSM decides whether they take effect.
  // ---------------------------------------------------------------------------
  logic        fetch_win;
  logic        loader_win;
  logic [31:0] sel_addr;
  logic        sel_write;
  logic        addr_err;
  logic        rsp_done;

  always_comb begin
    // Fetch only displaces a valid loader request once it has been passed
    // over STARVE_MAX times.
    fetch_win  = f_req_valid && (!l_req_valid || (starve_cnt == STARVE_LIM));
    loader_win = l_req_valid && !fetch_win;
    sel_addr   = loader_win ? l_req_addr : f_req_addr;
    sel_write  = loader_win && l_req_we;
    // Misaligned, or word index beyond the array.
    addr_err   = (sel_addr[1:0] != 2'b00) ||
                 ({2'b00, sel_addr[31:2]} >= 32'(DEPTH));
    // Response handshake on whichever port owns the transaction.
    rsp_done   = (owner == OWN_FETCH) ? f_rsp_ready : l_rsp_ready;
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every next-state value and output is defaulted before the case so
    // no path through this block leaves a signal unassigned (no latches).
    state_d      = state;
    owner_d      = owner;
    rsp_data_d   = rsp_data;
    rsp_err_d    = rsp_err;
    starve_cnt_d = starve_cnt;

    f_req_ready  = 1'b0;
    l_req_ready  = 1'b0;
    f_rsp_valid  = 1'b0;
    f_rsp_data   = '0;
    f_rsp_err    = 1'b0;
    l_rsp_valid  = 1'b0;
    l_rsp_data   = '0;
    l_rsp_err    = 1'b0;
    mem_en       = 1'b0;
    mem_we       = '0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state)
      IDLE: begin
        f_req_ready = fetch_win;
        l_req_ready = loader_win;

        if (fetch_win || loader_win) begin
          owner_d = loader_win ? OWN_LOADER : OWN_FETCH;

          // Count loader grants that made fetch wait; a fetch grant resets it.
          if (fetch_win) begin
            starve_cnt_d = '0;
          end else if (f_req_valid && (starve_cnt != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt + 1'b1;
          end

          if (addr_err) begin
            // Bad address never reaches the memory; answer straight away.
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = RSP;
          end else begin
            mem_en     = 1'b1;
            mem_addr   = sel_addr[IW+1:2];
            rsp_data_d = '0;
            rsp_err_d  = 1'b0;
            if (sel_write) begin
              // A zero byte-enable write is a legal no-op but is still acked.
              mem_we    = l_req_be;
              mem_wdata = l_req_wdata;
              state_d   = RSP;
            end else begin
              state_d   = RD_WAIT;
            end
          end
        end
      end

      RD_WAIT: begin
        // Memory read data is valid exactly one cycle after the strobe.
        rsp_data_d = mem_rdata;
        state_d    = RSP;
      end

      RSP: begin
        // Response is steered only to the port that owns the transaction and
        // is held from registers until that port takes it.
        if (owner == OWN_FETCH) begin
          f_rsp_valid = 1'b1;
          f_rsp_data  = rsp_data;
          f_rsp_err   = rsp_err;
        end else begin
          l_rsp_valid = 1'b1;
          l_rsp_data  = rsp_data;
          l_rsp_err   = rsp_err;
        end
        // Return to IDLE without accepting anything in the handshake cycle.
        if (rsp_done) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // While reset is asserted every output is forced low, including the
    // combinational readies and memory strobe.
    if (!rst) begin
      f_req_ready = 1'b0;
      l_req_ready = 1'b0;
      f_rsp_valid = 1'b0;
      f_rsp_data  = '0;
      f_rsp_err   = 1'b0;
      l_rsp_valid = 1'b0;
      l_rsp_data  = '0;
      l_rsp_err   = 1'b0;
      mem_en      = 1'b0;
      mem_we      = '0;
      mem_addr    = '0;
      mem_wdata   = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State register. A pending response is discarded by reset; a write that was
  // already strobed into the memory stays committed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_FETCH;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      rsp_data   <= rsp_data_d;
      rsp_err    <= rsp_err_d;
      starve_cnt <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//
// Directed and randomized transactions against imem_arbiter with a behavioural
// memory attached. Expected responses come from a word-level shadow memory and
// the arbitration rule (loader first, fetch after STARVE_MAX passes).
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

  localparam int DEPTH      = 1024;
  localparam int STARVE_MAX = 4;
  localparam int IW         = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req_valid, f_req_ready;
  logic [31:0]   f_req_addr;
  logic          f_rsp_valid, f_rsp_ready;
  logic [31:0]   f_rsp_data;
  logic          f_rsp_err;
  logic          l_req_valid, l_req_ready, l_req_we;
  logic [31:0]   l_req_addr, l_req_wdata;
  logic [3:0]    l_req_be;
  logic          l_rsp_valid, l_rsp_ready;
  logic [31:0]   l_rsp_data;
  logic          l_rsp_err;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [IW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready),
    .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
    .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_we(l_req_we),
    .l_req_addr(l_req_addr), .l_req_wdata(l_req_wdata), .l_req_be(l_req_be),
    .l_rsp_valid(l_rsp_valid), .l_rsp_ready(l_rsp_ready),
    .l_rsp_data(l_rsp_data), .l_rsp_err(l_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Shadow memory: expected contents, updated by the write rule.
  logic [31:0] ref_mem [DEPTH];

  // Behavioural single-port memory; preloaded from ref_mem on the first edge.
  logic [31:0] mem [DEPTH];
  logic        mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
      mem_loaded <= 1'b1;
    end else if (mem_en) begin
      logic [31:0] w;
      w = mem[mem_addr];
      for (int b = 0; b < 4; b++) if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
      mem[mem_addr] <= w;
      if (mem_we == 4'h0) mem_rdata <= mem[mem_addr];
    end
  end

  // Loader grants taken while fetch was requesting since fetch was last served.
  int lwins = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rsp_v(input bit l);
    return l ? l_rsp_valid : f_rsp_valid;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      1:       return 32'h0000_1000 + (32'($urandom_range(0, 4000)) << 2);
      default: return 32'($urandom_range(0, 15)) << 2;
    endcase
  endfunction

  task automatic rand_loader();
    l_req_we    = 1'($urandom_range(0, 1));
    l_req_addr  = rand_addr();
    l_req_wdata = $urandom;
    l_req_be    = 4'($urandom_range(0, 15));
  endtask

  // One complete transaction. Entered shortly after a falling edge with the
  // request fields already set; leaves shortly after a falling edge.
  task automatic step_txn(input bit want_f, input bit want_l, input int hold,
                          input bit rst_mid, output bit won_l);
    bit          win_l, rd, exp_err, f_prev, l_prev;
    logic [31:0] a, exp_data, got;
    logic        got_err;
    int          lat, exp_lat;
    logic [IW-1:0] idx;

    f_req_valid = want_f;
    l_req_valid = want_l;
    #1;
    win_l = want_l && !(want_f && (lwins == STARVE_MAX));
    won_l = win_l;
    check("f_req_ready", 32'(f_req_ready), 32'(!win_l));
    check("l_req_ready", 32'(l_req_ready), 32'(win_l));

    a       = win_l ? l_req_addr : f_req_addr;
    exp_err = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    rd      = !(win_l && l_req_we);
    idx     = a[IW+1:2];
    check("mem_en", 32'(mem_en), 32'(!exp_err));
    check("mem_we", 32'(mem_we), (!exp_err && !rd) ? 32'(l_req_be) : 32'h0);
    if (!exp_err) check("mem_addr", 32'(mem_addr), 32'(idx));
    if (!exp_err && !rd) check("mem_wdata", mem_wdata, l_req_wdata);

    exp_data = (exp_err || !rd) ? 32'h0 : ref_mem[idx];
    if (!exp_err && !rd)
      for (int b = 0; b < 4; b++)
        if (l_req_be[b]) ref_mem[idx][8*b +: 8] = l_req_wdata[8*b +: 8];
    if (!win_l) lwins = 0;
    else if (want_f && lwins < STARVE_MAX) lwins++;

    @(posedge clk);
    @(negedge clk); #1;
    if (win_l) l_req_valid = 1'b0; else f_req_valid = 1'b0;
    lat = 1;
    while (rsp_v(win_l) !== 1'b1 && lat < 6) begin
      check("busy_ready", 32'(f_req_ready | l_req_ready | mem_en), 32'h0);
      @(negedge clk); #1;
      lat++;
    end
    exp_lat = (rd && !exp_err) ? 2 : 1;
    check("latency", 32'(lat), 32'(exp_lat));
    got     = win_l ? l_rsp_data : f_rsp_data;
    got_err = win_l ? l_rsp_err  : f_rsp_err;
    check("rsp_data", got, exp_data);
    check("rsp_err", 32'(got_err), 32'(exp_err));
    check("other_rsp_valid", 32'(win_l ? f_rsp_valid : l_rsp_valid), 32'h0);

    // Raise both requests while the response is outstanding: none may be taken.
    f_prev = f_req_valid;
    l_prev = l_req_valid;
    f_req_valid = 1'b1;
    l_req_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      check("hold_valid", 32'(rsp_v(win_l)), 32'h1);
      check("hold_data", win_l ? l_rsp_data : f_rsp_data, got);
      check("hold_err", 32'(win_l ? l_rsp_err : f_rsp_err), 32'(got_err));
      check("hold_ready", 32'(f_req_ready | l_req_ready | mem_en), 32'h0);
    end

    if (rst_mid) begin
      rst = 1'b0;
      #1;
      check("rst_outputs", 32'({f_rsp_valid, l_rsp_valid, f_req_ready, l_req_ready, mem_en}), 32'h0);
      @(posedge clk);
      @(negedge clk); #1;
      rst = 1'b1;
      f_req_valid = f_prev;
      l_req_valid = l_prev;
      lwins = 0;
      #1;
      check("rsp_dropped", 32'(f_rsp_valid | l_rsp_valid), 32'h0);
    end else begin
      if (win_l) l_rsp_ready = 1'b1; else f_rsp_ready = 1'b1;
      #1;
      check("handshake_no_accept", 32'(f_req_ready | l_req_ready | mem_en), 32'h0);
      @(posedge clk);
      @(negedge clk); #1;
      f_rsp_ready = 1'b0;
      l_rsp_ready = 1'b0;
      f_req_valid = f_prev;
      l_req_valid = l_prev;
      #1;
      check("rsp_released", 32'(rsp_v(win_l)), 32'h0);
    end
  endtask

  initial begin
    bit won;
    bit pend_f, pend_l;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
    ref_mem[2] = 32'hDEAD_BEEF;

    // Reset held with both requesters active: everything stays quiet.
    rst = 1'b0;
    f_req_valid = 1'b1; f_req_addr = 32'h0;
    l_req_valid = 1'b1; l_req_we = 1'b0; l_req_addr = 32'h4;
    l_req_wdata = 32'h0; l_req_be = 4'h0;
    f_rsp_ready = 1'b0; l_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("reset_quiet", 32'({f_req_ready, l_req_ready, f_rsp_valid, l_rsp_valid, mem_en, mem_we}), 32'h0);
    end
    rst = 1'b1;
    #1;
    check("idle_after_reset_l", 32'(l_req_ready), 32'h1);
    check("idle_after_reset_f", 32'(f_req_ready), 32'h0);
    f_req_valid = 1'b0;
    l_req_valid = 1'b0;

    // Aligned fetch of a preloaded word.
    f_req_addr = 32'h8;
    step_txn(1'b1, 1'b0, 0, 1'b0, won);

    // Partial write then read-back of the merged word.
    l_req_we = 1'b1; l_req_addr = 32'h10; l_req_wdata = 32'h1234_5678; l_req_be = 4'b0011;
    step_txn(1'b0, 1'b1, 0, 1'b0, won);
    f_req_addr = 32'h10;
    step_txn(1'b1, 1'b0, 0, 1'b0, won);

    // Zero byte-enable write is acked and changes nothing.
    l_req_we = 1'b1; l_req_addr = 32'h10; l_req_wdata = 32'hFFFF_FFFF; l_req_be = 4'b0000;
    step_txn(1'b0, 1'b1, 0, 1'b0, won);
    l_req_we = 1'b0;
    step_txn(1'b0, 1'b1, 0, 1'b0, won);

    // Address errors: misaligned, just past the end, misaligned loader write.
    f_req_addr = 32'h2;
    step_txn(1'b1, 1'b0, 0, 1'b0, won);
    f_req_addr = 32'(DEPTH * 4);
    step_txn(1'b1, 1'b0, 0, 1'b0, won);
    f_req_addr = 32'(DEPTH * 4 - 4);
    step_txn(1'b1, 1'b0, 0, 1'b0, won);
    l_req_we = 1'b1; l_req_addr = 32'h11; l_req_wdata = 32'hA5A5_A5A5; l_req_be = 4'hF;
    step_txn(1'b0, 1'b1, 0, 1'b0, won);
    f_req_addr = 32'h10;
    step_txn(1'b1, 1'b0, 0, 1'b0, won);

    // Response stalled for five cycles, then another stalled and cut by reset.
    f_req_addr = 32'h8;
    step_txn(1'b1, 1'b0, 5, 1'b0, won);
    f_req_addr = 32'hC;
    step_txn(1'b1, 1'b0, 3, 1'b1, won);

    // Continuous contention: grants go L,L,L,L,F repeating.
    f_req_addr = rand_addr();
    rand_loader();
    for (int k = 0; k < 15; k++) begin
      step_txn(1'b1, 1'b1, int'($urandom_range(0, 2)), 1'b0, won);
      check("grant_order", 32'(won), 32'((k % 5) != 4));
      if (won) rand_loader(); else f_req_addr = rand_addr();
    end
    // Both requests are still pending here; serve them out.
    step_txn(1'b1, 1'b1, 0, 1'b0, won);
    if (won) step_txn(1'b1, 1'b0, 0, 1'b0, won);
    else     step_txn(1'b0, 1'b1, 0, 1'b0, won);

    // Random mix of requests; a losing request stays asserted until granted.
    pend_f = 1'b0;
    pend_l = 1'b0;
    for (int it = 0; it < 60; it++) begin
      if (!pend_f && $urandom_range(0, 1) == 1) begin
        f_req_addr = rand_addr();
        pend_f = 1'b1;
      end
      if (!pend_l && ($urandom_range(0, 1) == 1 || !pend_f)) begin
        rand_loader();
        pend_l = 1'b1;
      end
      step_txn(pend_f, pend_l, int'($urandom_range(0, 2)), 1'b0, won);
      if (won) pend_l = 1'b0; else pend_f = 1'b0;
    end
    if (pend_f || pend_l) step_txn(pend_f, pend_l, 0, 1'b0, won);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
